// File: rtl/booth_seq_mul.sv
// rtl/booth_seq_mul.sv - iterative signed Booth multiplier with valid/ready handshakes (radix-4 under BOOTH_SEQ_MUL_RADIX4_EN)
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_SEQ_MUL_RADIX4_EN
    localparam int AW = WIDTH + 2;
    localparam int N  = WIDTH / 2;
`else
    localparam int AW = WIDTH + 1;
    localparam int N  = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [AW-1:0]        m_ext, a_sum, a_nxt;
    logic [WIDTH-1:0]     q_nxt;
    logic                 qm1_nxt;

    // One Booth step: add the recoded partial product, then shift {A,Q,q_m1} right arithmetically.
    always_comb begin
        m_ext = {{(AW-WIDTH){m_q[WIDTH-1]}}, m_q};
`ifdef BOOTH_SEQ_MUL_RADIX4_EN
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: a_sum = a_q + m_ext;
            3'b011:         a_sum = a_q + (m_ext << 1);
            3'b100:         a_sum = a_q - (m_ext << 1);
            3'b101, 3'b110: a_sum = a_q - m_ext;
            default:        a_sum = a_q;
        endcase
        a_nxt   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        q_nxt   = {a_sum[1:0], q_q[WIDTH-1:2]};
        qm1_nxt = q_q[1];
`else
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        a_nxt   = {a_sum[AW-1], a_sum[AW-1:1]};
        q_nxt   = {a_sum[0], q_q[WIDTH-1:1]};
        qm1_nxt = q_q[0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = multiplicand;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_nxt;
                q_d   = q_nxt;
                qm1_d = qm1_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    product_d = {a_nxt[WIDTH-1:0], q_nxt};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb/tb_booth_seq_mul.sv - scoreboard bench for booth_seq_mul against a signed-multiply reference
module tb_booth_seq_mul;
`ifdef BOOTH_SEQ_MUL_RADIX4_EN
    localparam int W = 16;
    localparam int N = W / 2;
`else
    localparam int W = 8;
    localparam int N = W;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [2*W-1:0] sb[$];

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb_;
        longint p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        p   = sa * sb_;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on product handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                sb.push_back(ref_mul(multiplicand, multiplier));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
                else check("product", 64'(product), 64'(sb.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 100) check("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic dir_op(input logic [W-1:0] m, input logic [W-1:0] q);
        int lat;
        do_op(m, q);
        lat = 0;
        for (int k = 0; k < 4 * N; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", 64'(lat), 64'(N));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 8 * N; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    logic [W-1:0]   w_min, w_max, w_m5, w_6;
    logic [2*W-1:0] bp_exp;
    int             acc[3];

    initial begin
        w_min = {1'b1, {(W-1){1'b0}}};
        w_max = {1'b0, {(W-1){1'b1}}};
        w_m5  = W'(-5);
        w_6   = W'(6);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        rst_n = 1'b1;

        dir_op(W'(7), W'(3));
        dir_op(w_min, w_min);
        dir_op(w_min, w_max);
        dir_op(W'(0), {W{1'b1}});
        dir_op(w_max, w_min);
        check("hold_after_consume", 64'(product), 64'(ref_mul(w_max, w_min)));

        // Backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        bp_exp = ref_mul(w_m5, w_6);
        do_op(w_m5, w_6);
        for (int k = 0; k < 4 * N; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            multiplicand = W'(k + 1);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_product", 64'(product), 64'(bp_exp));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset during RUN
        do_op(W'(100), W'(100));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dir_op(W'(2), W'(-3));
        check("after_rst_product", 64'(product), 64'(ref_mul(W'(2), W'(-3))));

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            wait_ready();
            @(posedge clk);
            #1;
            acc[k] = cyc;
        end
        in_valid = 1'b0;
        check("b2b_spacing0", 64'(acc[1] - acc[0]), 64'(N + 2));
        check("b2b_spacing1", 64'(acc[2] - acc[1]), 64'(N + 2));
        drain();

        // Random sweep
        for (int k = 0; k < 1000; k++) begin
            do_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
